// File: rtl/blit_write_coalescer_pkg.sv
// Shared types and helpers for the blitter write coalescer: pixel sizes,
// lane geometry derived from the SDRAM word width, and byte-strobe generation.
package blit_pkg;

  typedef enum logic [1:0] {
    SIZE_8  = 2'd0,
    SIZE_16 = 2'd1,
    SIZE_32 = 2'd2
  } pixel_size_t;

  localparam int MAX_LANES = 8;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lane_idx_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Strobes for a pixel of the given size placed at an already aligned lane; size 3 yields none.
  function automatic logic [MAX_LANES-1:0] size_strobe(input logic [1:0] size, input logic [2:0] lane);
    logic [MAX_LANES-1:0] base;
    case (size)
      SIZE_8:  base = 8'h01;
      SIZE_16: base = 8'h03;
      SIZE_32: base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/blit_write_coalescer_wfifo.sv
// Generic registered FIFO: DEPTH entries of WIDTH bits, head presented from
// storage, zeroed while empty so downstream sees clean idle values.
module blit_wfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign head_o  = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    wr_ptr_d  = do_push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only observable through a valid head.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/blit_write_coalescer.sv
// Blitter write back-end: merges pixel writes into strobed SDRAM words and buffers them.
// Optional BLIT_WCOMB_STATS_EN adds pixel/word counters with a synchronous clear.
module blit_write_coalescer
  import blit_pkg::*;
#(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_address,
  input  logic [1:0]              in_size,
  input  logic [31:0]             in_wdata,
  input  logic                    flush,
  output logic                    idle,
  output logic                    fifo_full,
  output logic [$clog2(DEPTH):0]  fifo_slots_free,
  output logic                    sdram_request,
  input  logic                    sdram_ready,
  output logic [ADDR_W-1:0]       sdram_address,
  output logic [DATA_W/8-1:0]     sdram_wstrb,
  output logic [DATA_W-1:0]       sdram_wdata
`ifdef BLIT_WCOMB_STATS_EN
  ,
  input  logic                    stat_clear,
  output logic [31:0]             stat_words,
  output logic [31:0]             stat_pixels
`endif
);

  localparam int LANES = lane_count(DATA_W);
  localparam int LIDX  = lane_idx_w(DATA_W);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int FW    = ADDR_W + LANES + DATA_W;

  logic              cv_q, cv_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [LANES-1:0]  cstrb_q, cstrb_d;
  logic [DATA_W-1:0] cdata_q, cdata_d;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;

  logic [2:0]        lane_raw_s, lane_s;
  logic [LANES-1:0]  strb_s;
  logic [DATA_W-1:0] mask_s, shifted_s;
  logic [ADDR_W-1:0] waddr_s;
  logic              legal_s, same_s, mismatch_s, acc_s, timeout_hit_s, auto_s, push_s, pop_s;
  logic [FW-1:0]     push_entry_s, head_s;
  logic              empty_s;
  logic [CW-1:0]     count_s;

  // Pixel decode: alignment by size, lane strobes, byte mask and shifted data.
  always_comb begin
    lane_raw_s = 3'(in_address[LIDX-1:0]);
    case (in_size)
      2'd1:    lane_s = lane_raw_s & 3'b110;
      2'd2:    lane_s = lane_raw_s & 3'b100;
      default: lane_s = lane_raw_s;
    endcase
    strb_s    = LANES'(size_strobe(in_size, lane_s));
    shifted_s = DATA_W'(in_wdata) << {lane_s, 3'b000};
    mask_s    = {DATA_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      mask_s[8*i +: 8] = {8{strb_s[i]}};
    end
    waddr_s = {in_address[ADDR_W-1:LIDX], {LIDX{1'b0}}};
  end

  assign legal_s       = (in_size != 2'd3);
  assign same_s        = cv_q && (caddr_q == waddr_s);
  assign mismatch_s    = cv_q && legal_s && !same_s;
  assign in_ready      = !(mismatch_s && fifo_full);
  assign acc_s         = in_valid && in_ready;
  assign timeout_hit_s = (TIMEOUT != 0) && (idle_cnt_q == TO_W'(TIMEOUT));
  assign auto_s        = cv_q && !fifo_full && ((&cstrb_q) || flush || timeout_hit_s);

  // Combine-register next state; a mismatch push on accept outranks the idle triggers.
  always_comb begin
    cv_d         = cv_q;
    caddr_d      = caddr_q;
    cstrb_d      = cstrb_q;
    cdata_d      = cdata_q;
    push_s       = 1'b0;
    push_entry_s = {caddr_q, cstrb_q, cdata_q};
    if (acc_s && legal_s) begin
      push_s = mismatch_s;
      cv_d   = 1'b1;
      if (same_s) begin
        cstrb_d = cstrb_q | strb_s;
        cdata_d = (cdata_q & ~mask_s) | (shifted_s & mask_s);
      end else begin
        caddr_d = waddr_s;
        cstrb_d = strb_s;
        cdata_d = shifted_s & mask_s;
      end
    end else if (auto_s) begin
      push_s  = 1'b1;
      cv_d    = 1'b0;
      caddr_d = {ADDR_W{1'b0}};
      cstrb_d = {LANES{1'b0}};
      cdata_d = {DATA_W{1'b0}};
    end else begin
      cv_d = cv_q;
    end

    if (acc_s || !cv_q || push_s) begin
      idle_cnt_d = {TO_W{1'b0}};
    end else if (idle_cnt_q != TO_W'(TIMEOUT)) begin
      idle_cnt_d = idle_cnt_q + TO_W'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  // Combine register and idle counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cv_q       <= 1'b0;
      caddr_q    <= {ADDR_W{1'b0}};
      cstrb_q    <= {LANES{1'b0}};
      cdata_q    <= {DATA_W{1'b0}};
      idle_cnt_q <= {TO_W{1'b0}};
    end else begin
      cv_q       <= cv_d;
      caddr_q    <= caddr_d;
      cstrb_q    <= cstrb_d;
      cdata_q    <= cdata_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  blit_wfifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .full_o      (fifo_full),
    .empty_o     (empty_s),
    .count_o     (count_s)
  );

  assign sdram_request   = !empty_s;
  assign pop_s           = sdram_request && sdram_ready;
  assign {sdram_address, sdram_wstrb, sdram_wdata} = head_s;
  assign fifo_slots_free = CW'(DEPTH) - count_s;
  assign idle            = !cv_q && empty_s;

`ifdef BLIT_WCOMB_STATS_EN
  logic [31:0] stat_words_q, stat_words_d, stat_pixels_q, stat_pixels_d;

  // Statistics next state; clear wins over a same-cycle increment.
  always_comb begin
    if (stat_clear) begin
      stat_words_d  = 32'd0;
      stat_pixels_d = 32'd0;
    end else begin
      stat_words_d  = stat_words_q + (pop_s ? 32'd1 : 32'd0);
      stat_pixels_d = stat_pixels_q + (acc_s ? 32'd1 : 32'd0);
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_words_q  <= 32'd0;
      stat_pixels_q <= 32'd0;
    end else begin
      stat_words_q  <= stat_words_d;
      stat_pixels_q <= stat_pixels_d;
    end
  end

  assign stat_words  = stat_words_q;
  assign stat_pixels = stat_pixels_q;
`endif

endmodule
